// File: rtl/utmi_link_tx.sv
// SIE-side UTMI packet transmitter: checks the PID, appends CRC16 to data packets,
// hands bytes to the PHY under tx_ready and enforces the inter-packet gap.
module utmi_link_tx #(
  parameter int unsigned w   = 8,
  parameter int unsigned IPG = 4
) (
  input  logic         clk_60mhz,
  input  logic         rst,
  input  logic [w-1:0] s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  output logic [w-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         pkt_done,
  output logic         pid_err,
  output logic         underrun
);

  localparam int unsigned GAP_W = 4;
  localparam int unsigned CRC_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PAYLOAD   = 3'd1,
    CRC_LO    = 3'd2,
    CRC_HI    = 3'd3,
    LAST_WAIT = 3'd4,
    DRAIN     = 3'd5
  } state_t;

  state_t             state, state_d;
  logic [CRC_W-1:0]   crc, crc_d;
  logic [GAP_W-1:0]   gap_cnt, gap_d;
  logic [w-1:0]       tx_data_d;
  logic               tx_valid_d, busy_d, is_data, is_data_d, pid_err_d, underrun_d;
  logic               free, gap_zero, xfer, pid_ok, pid_data, underrun_c;

  // Reflected CRC16 (x^16+x^15+x^2+1), one byte per call, LSB first
  function automatic logic [CRC_W-1:0] crc16_upd(input logic [CRC_W-1:0] c_in,
                                                 input logic [w-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int unsigned i = 0; i < w; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  assign free       = !tx_valid || tx_ready;
  assign gap_zero   = (gap_cnt == '0);
  assign s_ready    = rst && ((((state == IDLE) && gap_zero) || (state == PAYLOAD)) && free
                              || (state == DRAIN));
  assign xfer       = s_valid && s_ready;
  assign pid_ok     = (s_data[7:4] == ~s_data[3:0]);
  assign pid_data   = (s_data[1:0] == 2'b11);
  assign underrun_c = (state == PAYLOAD) && tx_valid && tx_ready && !s_valid;
  // Flags the final byte in the very cycle the PHY takes it
  assign pkt_done   = rst && (state == LAST_WAIT) && tx_valid && tx_ready;

  always_ff @(posedge clk_60mhz) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (!pid_ok)     state_d = s_last ? IDLE : DRAIN;
          else if (s_last) state_d = pid_data ? CRC_LO : LAST_WAIT;
          else             state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer && s_last) state_d = is_data ? CRC_LO : LAST_WAIT;
        else if (underrun_c) state_d = DRAIN;
      end
      CRC_LO:    if (free) state_d = CRC_HI;
      CRC_HI:    if (free) state_d = LAST_WAIT;
      LAST_WAIT: if (tx_ready) state_d = IDLE;
      DRAIN:     if (xfer && s_last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the output register, CRC, gap counter and status flags
  always_comb begin
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    crc_d      = crc;
    gap_d      = gap_cnt;
    busy_d     = busy;
    is_data_d  = is_data;
    pid_err_d  = 1'b0;
    underrun_d = 1'b0;
    if (tx_valid && tx_ready) tx_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (!gap_zero) gap_d = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) busy_d = 1'b0;
        if (xfer) begin
          if (!pid_ok) begin
            pid_err_d = 1'b1;
          end else begin
            tx_data_d  = s_data;
            tx_valid_d = 1'b1;
            busy_d     = 1'b1;
            crc_d      = 16'hFFFF;
            is_data_d  = pid_data;
          end
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          tx_data_d  = s_data;
          tx_valid_d = 1'b1;
          if (is_data) crc_d = crc16_upd(crc, s_data);
        end
        if (underrun_c) underrun_d = 1'b1;
      end
      CRC_LO: begin
        if (free) begin
          tx_data_d  = ~crc[7:0];
          tx_valid_d = 1'b1;
        end
      end
      CRC_HI: begin
        if (free) begin
          tx_data_d  = ~crc[15:8];
          tx_valid_d = 1'b1;
        end
      end
      LAST_WAIT: if (tx_ready) gap_d = GAP_W'(IPG);
      DRAIN:     if (xfer && s_last) gap_d = GAP_W'(IPG);
      default: ;
    endcase
  end

  always_ff @(posedge clk_60mhz) begin
    if (!rst) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      crc      <= 16'hFFFF;
      gap_cnt  <= '0;
      busy     <= 1'b0;
      is_data  <= 1'b0;
      pid_err  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      crc      <= crc_d;
      gap_cnt  <= gap_d;
      busy     <= busy_d;
      is_data  <= is_data_d;
      pid_err  <= pid_err_d;
      underrun <= underrun_d;
    end
  end

endmodule

// File: tb/tb_utmi_link_tx.sv
// Bench for utmi_link_tx: per-cycle vector table plus streamed packets checked
// against an independent bit-serial CRC16 model and a known-answer CRC.
module tb_utmi_link_tx;

  localparam int unsigned W   = 8;
  localparam int unsigned IPG = 4;

  logic         clk_60mhz = 1'b0;
  logic         rst;
  logic [W-1:0] s_data;
  logic         s_valid, s_last, s_ready;
  logic [W-1:0] tx_data;
  logic         tx_valid, tx_ready, busy, pkt_done, pid_err, underrun;

  utmi_link_tx #(.w(W), .IPG(IPG)) dut (
    .clk_60mhz (clk_60mhz),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pid_err   (pid_err),
    .underrun  (underrun)
  );

  always #8 clk_60mhz = ~clk_60mhz;

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic       v, l, tr;
    logic       sr, tv;
    logic [7:0] td;
    logic       bz, pd, pe, ur;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] stim_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [7:0] d, input logic v, input logic l,
                              input logic tr, input logic sr, input logic tv,
                              input logic [7:0] td, input logic bz, input logic pd,
                              input logic pe, input logic ur);
    vec_t x;
    x.rst = r; x.d = d; x.v = v; x.l = l; x.tr = tr;
    x.sr = sr; x.tv = tv; x.td = td; x.bz = bz; x.pd = pd; x.pe = pe; x.ur = ur;
    vecs.push_back(x);
  endfunction

  // Non-reflected MSB-first CRC (poly 8005) fed LSB-first, bit-reversed and complemented
  function automatic logic [15:0] crc_ref();
    logic [15:0] r;
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    r = 16'hFFFF;
    for (int k = 1; k < stim_q.size(); k++) begin
      b = stim_q[k];
      for (int i = 0; i < 8; i++) begin
        fb = r[15] ^ b[i];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) c[i] = r[15-i];
    return ~c;
  endfunction

  task automatic run_pkt(input string name, input bit toggle);
    int         idx;
    int         cyc;
    bit         started, done, hold;
    logic [7:0] hold_d;
    idx = 0; cyc = 0; started = 0; done = 0; hold = 0; hold_d = '0;
    got_q.delete();
    while (!done && cyc < 300) begin
      @(negedge clk_60mhz);
      tx_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (idx < stim_q.size()) begin
        s_valid = 1'b1;
        s_data  = stim_q[idx];
        s_last  = (idx == stim_q.size() - 1);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      #1;
      if (hold) chk({name, " hold"}, {7'd0, tx_valid, tx_data}, {7'd0, 1'b1, hold_d});
      if (started) chk({name, " tx_valid"}, 16'(tx_valid), 16'd1);
      if (tx_valid) started = 1;
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      hold   = tx_valid && !tx_ready;
      hold_d = tx_data;
      if (s_valid && s_ready) idx++;
      if (pkt_done) done = 1;
      cyc++;
    end
    @(negedge clk_60mhz);
    s_valid  = 1'b0;
    s_last   = 1'b0;
    tx_ready = 1'b1;
    chk({name, " pkt_done"}, 16'(done), 16'd1);
    chk({name, " length"}, 16'(got_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s byte%0d", name, i), 16'(got_q[i]), 16'(exp_q[i]));
  endtask

  initial begin
    logic [15:0] crc;
    rst = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk_60mhz);

    // rst d v l tr | s_ready tx_valid tx_data busy pkt_done pid_err underrun
    add(0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    // DATA0 zero-length
    add(1, 8'hC3, 1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 1, 8'hC3, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 1, 8'h00, 1, 1, 0, 0);
    repeat (4) add(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    // ACK
    add(1, 8'hD2, 1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 1, 8'hD2, 1, 1, 0, 0);
    repeat (4) add(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    // bad PID then two bytes
    add(1, 8'hC4, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h11, 1, 0, 1, 1, 0, 8'h00, 0, 0, 1, 0);
    add(1, 8'h22, 1, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    repeat (4) add(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    // underrun
    add(1, 8'hC3, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'hAA, 1, 0, 1, 1, 1, 8'hC3, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 1, 1, 8'hAA, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, 1, 0, 0, 1);
    add(1, 8'h55, 1, 0, 1, 1, 0, 8'h00, 1, 0, 0, 0);
    add(1, 8'h66, 1, 1, 1, 1, 0, 8'h00, 1, 0, 0, 0);
    repeat (4) add(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    // reset mid-payload, then IN token with no gap
    add(1, 8'hC3, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h10, 1, 0, 0, 0, 1, 8'hC3, 1, 0, 0, 0);
    add(0, 8'h10, 1, 0, 0, 0, 1, 8'hC3, 1, 0, 0, 0);
    add(1, 8'h69, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h01, 1, 0, 1, 1, 1, 8'h69, 1, 0, 0, 0);
    add(1, 8'h02, 1, 1, 1, 1, 1, 8'h01, 1, 0, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 1, 8'h02, 1, 1, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk_60mhz);
      rst = vecs[i].rst; s_data = vecs[i].d; s_valid = vecs[i].v;
      s_last = vecs[i].l; tx_ready = vecs[i].tr;
      #1;
      chk($sformatf("v%0d s_ready", i),  16'(s_ready),  16'(vecs[i].sr));
      chk($sformatf("v%0d tx_valid", i), 16'(tx_valid), 16'(vecs[i].tv));
      if (vecs[i].tv || !vecs[i].rst)
        chk($sformatf("v%0d tx_data", i), 16'(tx_data), 16'(vecs[i].td));
      chk($sformatf("v%0d busy", i),     16'(busy),     16'(vecs[i].bz));
      chk($sformatf("v%0d pkt_done", i), 16'(pkt_done), 16'(vecs[i].pd));
      chk($sformatf("v%0d pid_err", i),  16'(pid_err),  16'(vecs[i].pe));
      chk($sformatf("v%0d underrun", i), 16'(underrun), 16'(vecs[i].ur));
    end
    @(negedge clk_60mhz);
    s_valid = 1'b0; s_last = 1'b0; tx_ready = 1'b1;

    // DATA1 payload with tx_ready toggling; CRC from the reference model
    stim_q = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03};
    crc    = crc_ref();
    exp_q  = stim_q;
    exp_q.push_back(crc[7:0]);
    exp_q.push_back(crc[15:8]);
    run_pkt("data1", 1'b1);

    // DATA0 carrying "123456789": CRC-16/USB check value 0xB4C8, low byte first
    stim_q = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp_q  = stim_q;
    exp_q.push_back(8'hC8);
    exp_q.push_back(8'hB4);
    run_pkt("kat", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
